// File: rtl/epl_ffram02_ecc_responder.sv
`default_nettype none
// ============================================================================
// Module   : epl_ffram02_ecc_responder
// Brief    : FFRAM02 memory-side responder, Hamming(7,4) SEC storage with
//            per-address read-disturb / write-failure fault injection.
// Revision : 1.0  initial release
// ============================================================================
module epl_ffram02_ecc_responder #(
  parameter logic [15:0] RD_WORD_MASK = 16'h000C,
  parameter logic [15:0] WF_WORD_MASK = 16'h0030,
  parameter logic [6:0]  RD_FLIP_MASK = 7'b0010000,
  parameter logic [6:0]  WF_FLIP_MASK = 7'b0000011
) (
  input  logic       pCLOCK_i,
  input  logic       nRESET_i,
  input  logic [3:0] pA_i,
  input  logic [3:0] pD_i,
  input  logic       nWEN_i,
  input  logic       nCEN_i,
  input  logic       pFS_i,
  output logic [3:0] pQ_o,
  output logic       pERR_o,
  output logic [6:0] pCcodeword1_o
);

  function automatic logic [6:0] f_enc(input logic [3:0] d);
    f_enc = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3], d[0],
             d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};
  endfunction

  function automatic logic [2:0] f_syn(input logic [6:0] c);
    f_syn = {c[3] ^ c[4] ^ c[5] ^ c[6],
             c[1] ^ c[2] ^ c[5] ^ c[6],
             c[0] ^ c[2] ^ c[4] ^ c[6]};
  endfunction

  // Stage 1: sampled command
  logic       r_s1_vld;
  logic       r_s1_wr;
  logic [3:0] r_s1_addr;
  logic [3:0] r_s1_data;
  logic       r_s1_inj;
  // Stage 2: encoded write / fetched read codeword
  logic       r_s2_wr_vld;
  logic       r_s2_rd_vld;
  logic [3:0] r_s2_addr;
  logic [6:0] r_cw;
  logic [6:0] r_rcw;
  // Stage 3: syndrome
  logic       r_s3_rd_vld;
  logic [2:0] r_syn;
  logic [6:0] r_s3_rcw;
  // Output stage
  logic [3:0] r_q;
  logic       r_err;

  logic [6:0] r_mem [16];

  logic [6:0] w_flip;
  logic [6:0] w_fixed;
  logic [3:0] w_q;
  logic       w_inj;

  assign w_inj   = pFS_i & (nWEN_i ? RD_WORD_MASK[pA_i] : WF_WORD_MASK[pA_i]);
  assign w_flip  = (r_syn != 3'd0) ? (7'b0000001 << (r_syn - 3'd1)) : 7'b0000000;
  assign w_fixed = r_s3_rcw ^ w_flip;
  assign w_q     = {w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]};

  always_ff @(posedge pCLOCK_i or negedge nRESET_i) begin
    if (!nRESET_i) begin
      r_s1_vld    <= 1'b0;
      r_s1_wr     <= 1'b0;
      r_s1_addr   <= 4'h0;
      r_s1_data   <= 4'h0;
      r_s1_inj    <= 1'b0;
      r_s2_wr_vld <= 1'b0;
      r_s2_rd_vld <= 1'b0;
      r_s2_addr   <= 4'h0;
      r_cw        <= 7'h00;
      r_rcw       <= 7'h00;
      r_s3_rd_vld <= 1'b0;
      r_syn       <= 3'd0;
      r_s3_rcw    <= 7'h00;
      r_q         <= 4'h0;
      r_err       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        r_mem[i] <= 7'h00;
      end
    end else begin
      // Inputs other than nCEN_i are don't-care on idle cycles, so gate capture.
      r_s1_vld <= ~nCEN_i;
      if (!nCEN_i) begin
        r_s1_wr   <= ~nWEN_i;
        r_s1_addr <= pA_i;
        r_s1_data <= pD_i;
        r_s1_inj  <= w_inj;
      end

      r_s2_wr_vld <= r_s1_vld & r_s1_wr;
      r_s2_rd_vld <= r_s1_vld & ~r_s1_wr;
      r_s2_addr   <= r_s1_addr;
      if (r_s1_vld && r_s1_wr) begin
        r_cw <= f_enc(r_s1_data) ^ (r_s1_inj ? WF_FLIP_MASK : 7'h00);
      end
      // Array sampled before this edge's commit: no write-to-read forwarding.
      if (r_s1_vld && !r_s1_wr) begin
        r_rcw <= r_mem[r_s1_addr] ^ (r_s1_inj ? RD_FLIP_MASK : 7'h00);
      end

      if (r_s2_wr_vld) begin
        r_mem[r_s2_addr] <= r_cw;
      end
      r_s3_rd_vld <= r_s2_rd_vld;
      if (r_s2_rd_vld) begin
        r_syn    <= f_syn(r_rcw);
        r_s3_rcw <= r_rcw;
      end

      if (r_s3_rd_vld) begin
        r_q   <= w_q;
        r_err <= (r_syn != 3'd0);
      end
    end
  end

  assign pQ_o          = r_q;
  assign pERR_o        = r_err;
  assign pCcodeword1_o = r_cw;

endmodule
`default_nettype wire

// File: doc/epl_ffram02_ecc_responder.md
Name: epl_ffram02_ecc_responder

Overview:
- Synthesizable memory-side responder for the FFRAM02 command port: accepts the nCEN/nWEN/pA/pD/pFS command protocol driven by host benches and controllers, and returns pQ/pERR with fixed latency.
- Stores each 4-bit word as a Hamming(7,4) codeword in a 16-entry register array.
- Decodes with single-error correction, and supports per-address fault injection for read-disturb and write-failure campaigns.

Parameters:
- RD_WORD_MASK, 16'h000C, addresses subject to read-disturb injection.
- WF_WORD_MASK, 16'h0030, addresses subject to write-failure injection.
- RD_FLIP_MASK, 7'b0010000, codeword bits XORed on an injected read (single bit → correctable).
- WF_FLIP_MASK, 7'b0000011, codeword bits XORed on an injected write (double bit → flagged).

Ports:
- pCLOCK_i  in  1  clock, rising-edge active.
- nRESET_i  in  1  reset; asynchronous, active-low.
- pA_i  in  4  word address (0..15).
- pD_i  in  4  write data.
- nWEN_i  in  1  0 = write, 1 = read; sampled only when nCEN_i = 0.
- nCEN_i  in  1  0 = command valid this edge.
- pFS_i  in  1  fault-select; qualifies injection for the sampled command.
- pQ_o  out  4  corrected read data.
- pERR_o  out  1  nonzero syndrome on the last completed read.
- pCcodeword1_o  out  7  last encoded write codeword, after WF injection.

Behaviour:
- Reset (nRESET_i = 0, asynchronous):
  - All 16 array entries = 7'h00, which is the valid codeword for data 0.
  - All pipeline valid bits = 0.
  - pQ_o = 0, pERR_o = 0, pCcodeword1_o = 0.
- Reset asserted mid-operation aborts all in-flight commands. No partial array writes are permitted.
- Encoding: cw[0]=d0^d1^d3, cw[1]=d0^d2^d3, cw[2]=d0, cw[3]=d1^d2^d3, cw[4]=d1, cw[5]=d2, cw[6]=d3.
- Decoding: syndrome s = {s4,s2,s1}, where s1=^cw[0,2,4,6], s2=^cw[1,2,5,6], s4=^cw[3,4,5,6].
  - If s ≠ 0, flip cw[s-1], then extract data.
  - pERR = (s ≠ 0).
- A command is sampled at posedge T0 when nCEN_i = 0. When nCEN_i = 1, all other inputs are ignored, including X.
- Write pipeline:
  - T0: capture addr, data, and inj = pFS_i & WF_WORD_MASK[addr].
  - T0+1: cw_reg = enc(data) ^ (inj ? WF_FLIP_MASK : 0); pCcodeword1_o = cw_reg.
  - T0+2: array[addr] = cw_reg.
- Read pipeline:
  - T0: capture addr and inj = pFS_i & RD_WORD_MASK[addr].
  - T0+1: rcw = array[addr] ^ (inj ? RD_FLIP_MASK : 0). The stored array is never modified by a read.
  - T0+2: register syndrome and rcw.
  - T0+3: register pQ_o and pERR_o.
  - Outputs hold until the next read completes. Writes never change pQ_o or pERR_o.
- Fully pipelined: one command may be accepted per cycle; reads and writes may be interleaved back-to-back.
- Hazard rule: the array read at T0+1 samples contents before that edge's commit.
  - A read sampled at N returns writes sampled at ≤ N-2.
  - A write sampled at N-1 is not visible to that read. Do not forward it.
- Injection only applies when pFS_i = 1 on the command cycle AND the address mask bit is set. pFS_i on idle cycles has no effect.
- Two writes to the same address on consecutive cycles: the later write wins.
- Address width is exact (16 entries), so no out-of-range handling is needed.

Test Plan:
1. Reset, then write addr 0..15 with data (0xA+i)&0xF, then read each with pFS=0.
   - Required: pQ = data, pERR = 0.
   - Required: pCcodeword1_o after the addr 0 write = 7'h52; after the addr 1 write = 7'h55.
2. Read-disturb: after scenario 1, read all addresses with pFS=1.
   - Addr 2 → pQ = 0xC, pERR = 1; addr 3 → pQ = 0xD, pERR = 1.
   - All other addresses → correct data, pERR = 0.
   - Rereading addr 2 with pFS=0 → 0xC, pERR = 0 (the array is unchanged).
3. Write-failure: pulse reset, write all addresses with pFS=1, then read with pFS=0.
   - Addr 4 → pCcodeword1_o = 7'h7B, read gives pQ = 0xF, pERR = 1.
   - Addr 5 → pERR = 1.
   - All other addresses → correct data, pERR = 0.
4. Latency and pipelining: issue a read of addr 7 at T0 and a read of addr 8 at T0+1.
   - pQ = 0x1 is registered at T0+3; pQ = 0x2 is registered at T0+4.
5. Hazard: write addr 9 = 0x5 at N-1, read addr 9 at N → old value; read again at N+1 → 0x5, pERR = 0.
6. Reset mid-write: assert nRESET_i between T0+1 and T0+2 of a write to addr 6 = 0x3.
   - Reading addr 6 afterwards → 0x0, pERR = 0.
   - pQ_o = 0 immediately on assertion.
